// File: rtl/mips_harvard_instr_rom_if.sv
`default_nettype none
// ============================================================================
// Module      : mips_harvard_instr_rom_if
// Description : Load, fetch and run-supervision signals of the instruction ROM.
// Revision    : 1.0  initial release
// ============================================================================
interface mips_harvard_instr_rom_if;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_full;
    logic        start;
    logic        cpu_reset;
    logic        cpu_active;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic        fault;
    logic        halted;
    logic        timed_out;
    logic [15:0] cycle_count;

    modport slave (
        input  load_valid, load_data, start, cpu_active, instr_address,
        output load_full, cpu_reset, instr_readdata, fault, halted,
               timed_out, cycle_count
    );

    modport master (
        output load_valid, load_data, start, cpu_active, instr_address,
        input  load_full, cpu_reset, instr_readdata, fault, halted,
               timed_out, cycle_count
    );
endinterface
`default_nettype wire

// File: rtl/mips_harvard_instr_rom.sv
`default_nettype none
// ============================================================================
// Module      : mips_harvard_instr_rom
// Description : Streamed-load instruction memory for a Harvard MIPS CPU, with
//               run supervision (start, halt on address 0, cycle timeout).
// Revision    : 1.0  initial release
// ============================================================================
module mips_harvard_instr_rom #(
    parameter int          DEPTH      = 256,
    parameter logic [31:0] BASE_ADDR  = 32'hBFC00000,
    parameter bit          SWAP_BYTES = 1'b1,
    parameter int          MAX_CYCLES = 1000
) (
    input  wire logic               clk,
    input  wire logic               reset,
    mips_harvard_instr_rom_if.slave bus
);

    localparam int          AW         = $clog2(DEPTH);
    localparam logic [32:0] SPAN_BYTES = 33'(DEPTH) * 33'd4;
    localparam logic [15:0] LAST_CYCLE = 16'(MAX_CYCLES - 1);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [AW:0]   r_ptr;
    logic [31:0]   r_mem [DEPTH];
    logic          r_fault;
    logic          r_halted;
    logic          r_timed_out;
    logic [15:0]   r_cycle_count;

    logic [31:0]   w_offset;
    logic [AW-1:0] w_idx;
    logic          w_fetch_valid;
    logic [31:0]   w_word;
    logic [31:0]   w_word_bus;
    logic          w_load_full;
    logic          w_load_we;
    logic          w_in_run;
    logic          w_halt;
    logic          w_timeout;
    logic          w_cpu_reset;

    // Fetch decode; the explicit lower-bound test keeps addresses below the
    // base from aliasing into the array after the subtraction wraps.
    always_comb begin
        w_offset      = bus.instr_address - BASE_ADDR;
        w_idx         = w_offset[AW+1:2];
        w_fetch_valid = (bus.instr_address[1:0] == 2'b00)
                     && (bus.instr_address >= BASE_ADDR)
                     && ({1'b0, w_offset} < SPAN_BYTES)
                     && ({1'b0, w_idx} < r_ptr);
        w_word        = w_fetch_valid ? r_mem[w_idx] : 32'h0;
    end

    generate
        if (SWAP_BYTES) begin : g_swap
            assign w_word_bus = {w_word[7:0], w_word[15:8],
                                 w_word[23:16], w_word[31:24]};
        end else begin : g_noswap
            assign w_word_bus = w_word;
        end
    endgenerate

    assign w_load_full = (r_ptr == (AW+1)'(DEPTH));
    assign w_load_we   = (r_state == S_LOAD) && bus.load_valid && !w_load_full;
    assign w_in_run    = (r_state == S_RUN);
    assign w_halt      = w_in_run && (bus.instr_address == 32'h0) && !bus.cpu_active;
    assign w_timeout   = w_in_run && (r_cycle_count == LAST_CYCLE) && !w_halt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cpu_reset  = 1'b1;
        case (r_state)
            S_LOAD: begin
                if (bus.start) begin
                    w_state_next = S_ARM;
                end
            end
            S_ARM: begin
                w_state_next = S_RUN;
            end
            S_RUN: begin
                w_cpu_reset = 1'b0;
                if (w_halt || w_timeout) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_DONE;
            end
            default: begin
                w_state_next = S_LOAD;
            end
        endcase
    end

    // Array contents survive reset; only the pointer gates what is readable.
    always_ff @(posedge clk) begin
        if (w_load_we) begin
            r_mem[r_ptr[AW-1:0]] <= bus.load_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_load_we) begin
            r_ptr <= r_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fault       <= 1'b0;
            r_halted      <= 1'b0;
            r_timed_out   <= 1'b0;
            r_cycle_count <= 16'h0;
        end else if (w_in_run) begin
            if (r_cycle_count != 16'hFFFF) begin
                r_cycle_count <= r_cycle_count + 16'h1;
            end
            // Address 0 is the halt vector, so it never counts as a bad fetch.
            if (!w_fetch_valid && (bus.instr_address != 32'h0)) begin
                r_fault <= 1'b1;
            end
            if (w_halt) begin
                r_halted <= 1'b1;
            end
            if (w_timeout) begin
                r_timed_out <= 1'b1;
            end
        end
    end

    assign bus.load_full      = w_load_full;
    assign bus.cpu_reset      = w_cpu_reset;
    assign bus.instr_readdata = w_word_bus;
    assign bus.fault          = r_fault;
    assign bus.halted         = r_halted;
    assign bus.timed_out      = r_timed_out;
    assign bus.cycle_count    = r_cycle_count;

endmodule
`default_nettype wire

// File: tb/tb_mips_harvard_instr_rom.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_harvard_instr_rom
// Description : Directed scoreboard bench for mips_harvard_instr_rom.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mips_harvard_instr_rom;

    localparam logic [31:0] A0 = 32'hBFC00000;

    typedef struct {
        string       nm;
        logic [31:0] rd;
        logic        cr;
        logic        lf;
        logic        ft;
        logic        hl;
        logic        to;
        logic [15:0] cnt;
    } exp_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    exp_t sb[$];

    mips_harvard_instr_rom_if bus ();

    mips_harvard_instr_rom #(
        .DEPTH      (4),
        .BASE_ADDR  (A0),
        .SWAP_BYTES (1'b1),
        .MAX_CYCLES (20)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string nm, input string fld,
                                input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
        end
    endfunction

    // Monitor: every falling edge with a pending expectation compares the bus.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk(e.nm, "readdata",  bus.instr_readdata,     e.rd);
                chk(e.nm, "cpu_reset", 32'(bus.cpu_reset),     32'(e.cr));
                chk(e.nm, "load_full", 32'(bus.load_full),     32'(e.lf));
                chk(e.nm, "fault",     32'(bus.fault),         32'(e.ft));
                chk(e.nm, "halted",    32'(bus.halted),        32'(e.hl));
                chk(e.nm, "timed_out", 32'(bus.timed_out),     32'(e.to));
                chk(e.nm, "count",     32'(bus.cycle_count),   32'(e.cnt));
            end
        end
    end

    task automatic cyc(input string nm, input logic rs, input logic lv,
                       input logic [31:0] ld, input logic st, input logic act,
                       input logic [31:0] ad, input logic [31:0] erd,
                       input logic ecr, input logic elf, input logic eft,
                       input logic ehl, input logic eto, input logic [15:0] ecnt);
        exp_t e;
        @(posedge clk);
        #1;
        reset             = rs;
        bus.load_valid    = lv;
        bus.load_data     = ld;
        bus.start         = st;
        bus.cpu_active    = act;
        bus.instr_address = ad;
        e.nm = nm; e.rd = erd; e.cr = ecr; e.lf = elf;
        e.ft = eft; e.hl = ehl; e.to = eto; e.cnt = ecnt;
        sb.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        bus.load_valid = 1'b0; bus.load_data = 32'h0; bus.start = 1'b0;
        bus.cpu_active = 1'b1; bus.instr_address = A0;

        // Load with overflow, range/alignment decode, start/arm, halt
        cyc("rst",    1, 0, 32'h0,        0, 1, A0,      32'h0,        1, 0, 0, 0, 0, 16'd0);
        cyc("idle",   0, 0, 32'h0,        0, 1, A0,      32'h0,        1, 0, 0, 0, 0, 16'd0);
        cyc("ld0",    0, 1, 32'h24420001, 0, 1, A0,      32'h0,        1, 0, 0, 0, 0, 16'd0);
        cyc("ld1",    0, 1, 32'h00000008, 0, 1, A0,      32'h01004224, 1, 0, 0, 0, 0, 16'd0);
        cyc("ld2",    0, 1, 32'h24420001, 0, 1, A0+4,    32'h08000000, 1, 0, 0, 0, 0, 16'd0);
        cyc("ld3",    0, 1, 32'h24000001, 0, 1, A0+8,    32'h01004224, 1, 0, 0, 0, 0, 16'd0);
        cyc("ldx0",   0, 1, 32'hDEAD0001, 0, 1, A0+12,   32'h01000024, 1, 1, 0, 0, 0, 16'd0);
        cyc("ldx1",   0, 1, 32'hDEAD0002, 0, 1, A0+16,   32'h0,        1, 1, 0, 0, 0, 16'd0);
        cyc("keep",   0, 0, 32'h0,        0, 1, A0+12,   32'h01000024, 1, 1, 0, 0, 0, 16'd0);
        cyc("misal",  0, 0, 32'h0,        0, 1, A0+2,    32'h0,        1, 1, 0, 0, 0, 16'd0);
        cyc("below",  0, 0, 32'h0,        0, 1, A0-4,    32'h0,        1, 1, 0, 0, 0, 16'd0);
        cyc("start",  0, 0, 32'h0,        1, 1, A0,      32'h01004224, 1, 1, 0, 0, 0, 16'd0);
        cyc("arm",    0, 0, 32'h0,        0, 1, A0+4,    32'h08000000, 1, 1, 0, 0, 0, 16'd0);
        cyc("run0",   0, 0, 32'h0,        0, 1, A0+4,    32'h08000000, 0, 1, 0, 0, 0, 16'd0);
        cyc("run1",   0, 0, 32'h0,        0, 1, A0,      32'h01004224, 0, 1, 0, 0, 0, 16'd1);
        cyc("zact",   0, 0, 32'h0,        0, 1, 32'h0,   32'h0,        0, 1, 0, 0, 0, 16'd2);
        cyc("zhalt",  0, 0, 32'h0,        0, 0, 32'h0,   32'h0,        0, 1, 0, 0, 0, 16'd3);
        cyc("done0",  0, 0, 32'h0,        1, 1, A0,      32'h01004224, 1, 1, 0, 1, 0, 16'd4);
        cyc("done1",  0, 0, 32'h0,        0, 1, A0,      32'h01004224, 1, 1, 0, 1, 0, 16'd4);

        // Load+start together, sticky fault, timeout at MAX_CYCLES
        cyc("rst2",   1, 0, 32'h0,        0, 1, A0,      32'h0,        1, 0, 0, 0, 0, 16'd0);
        cyc("r2ld0",  0, 1, 32'h12345678, 0, 1, A0,      32'h0,        1, 0, 0, 0, 0, 16'd0);
        cyc("r2ldst", 0, 1, 32'hAABBCCDD, 1, 1, A0,      32'h78563412, 1, 0, 0, 0, 0, 16'd0);
        cyc("r2arm",  0, 0, 32'h0,        0, 1, A0+4,    32'hDDCCBBAA, 1, 0, 0, 0, 0, 16'd0);
        cyc("r2bad",  0, 0, 32'h0,        0, 1, A0+8,    32'h0,        0, 0, 0, 0, 0, 16'd0);
        cyc("r2back", 0, 0, 32'h0,        0, 1, A0+4,    32'hDDCCBBAA, 0, 0, 1, 0, 0, 16'd1);
        for (int k = 2; k < 20; k++)
            cyc("r2run", 0, 0, 32'h0,     0, 1, A0,      32'h78563412, 0, 0, 1, 0, 0, 16'(k));
        cyc("r2to",   0, 0, 32'h0,        0, 1, A0,      32'h78563412, 1, 0, 1, 0, 1, 16'd20);
        cyc("r2hold", 0, 0, 32'h0,        1, 1, A0,      32'h78563412, 1, 0, 1, 0, 1, 16'd20);

        // Halt on the timeout edge: halt takes priority
        cyc("rst3",   1, 0, 32'h0,        0, 1, A0,      32'h0,        1, 0, 0, 0, 0, 16'd0);
        cyc("r3ldst", 0, 1, 32'h0BF00000, 1, 1, A0,      32'h0,        1, 0, 0, 0, 0, 16'd0);
        cyc("r3arm",  0, 0, 32'h0,        0, 1, A0,      32'h0000F00B, 1, 0, 0, 0, 0, 16'd0);
        for (int k = 0; k < 19; k++)
            cyc("r3run", 0, 0, 32'h0,     0, 1, A0,      32'h0000F00B, 0, 0, 0, 0, 0, 16'(k));
        cyc("r3last", 0, 0, 32'h0,        0, 0, 32'h0,   32'h0,        0, 0, 0, 0, 0, 16'd19);
        cyc("r3halt", 0, 0, 32'h0,        0, 1, A0,      32'h0000F00B, 1, 0, 0, 1, 0, 16'd20);

        // Asynchronous reset between edges in the middle of a run
        cyc("rst4",   1, 0, 32'h0,        0, 1, A0,      32'h0,        1, 0, 0, 0, 0, 16'd0);
        cyc("r4ldst", 0, 1, 32'h0BF00000, 1, 1, A0,      32'h0,        1, 0, 0, 0, 0, 16'd0);
        cyc("r4arm",  0, 0, 32'h0,        0, 1, A0,      32'h0000F00B, 1, 0, 0, 0, 0, 16'd0);
        cyc("r4run0", 0, 0, 32'h0,        0, 1, A0+4,    32'h0,        0, 0, 0, 0, 0, 16'd0);
        cyc("r4run1", 0, 0, 32'h0,        0, 1, A0,      32'h0000F00B, 0, 0, 1, 0, 0, 16'd1);
        cyc("r4arst", 1, 0, 32'h0,        0, 1, A0,      32'h0,        1, 0, 0, 0, 0, 16'd0);
        cyc("r4load", 0, 0, 32'h0,        0, 1, A0,      32'h0,        1, 0, 0, 0, 0, 16'd0);

        for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain actual=%0d required=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
